// File: rtl/elixirchip_es1_spu_op_logic_pkg.sv
// Shared definitions for the ES1 SPU multi-lane bitwise logic unit:
// operation encoding, parameter limits and the per-bit operation evaluator.
package elixirchip_es1_spu_op_logic_pkg;

    localparam int LATENCY_MAX  = 8;
    localparam int CHANNELS_MAX = 16;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    // Evaluated one bit at a time so the function is independent of lane width.
    function automatic logic op_eval_bit(input op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_logic_stage.sv
// One lane-vector pipeline stage: valid always advances, data is captured
// only on lanes whose incoming valid is set, otherwise it holds.
module elixirchip_es1_spu_op_logic_stage
    import elixirchip_es1_spu_op_logic_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cke,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]   s_data,
    input  logic [CHANNELS-1:0]                  s_valid,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]   m_data,
    output logic [CHANNELS-1:0]                  m_valid
);

    logic [CHANNELS-1:0][DATA_BITS-1:0] data_d;
    logic [CHANNELS-1:0][DATA_BITS-1:0] data_q;
    logic [CHANNELS-1:0]                valid_d;
    logic [CHANNELS-1:0]                valid_q;

    // Next-state selection per lane
    always_comb begin
        data_d  = data_q;
        valid_d = s_valid;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s_valid[i]) begin
                data_d[i] = s_data[i];
            end else begin
                data_d[i] = data_q[i];
            end
        end
    end

    // Stage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
        end else if (cke) begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/elixirchip_es1_spu_op_logic.sv
// ES1 SPU multi-lane bitwise logic unit: runtime-selected operation, per-lane
// valid, global clear, configurable latency (0 = purely combinational).
module elixirchip_es1_spu_op_logic
    import elixirchip_es1_spu_op_logic_pkg::*;
#(
    parameter int                   LATENCY    = 1,
    parameter int                   DATA_BITS  = 8,
    parameter int                   CHANNELS   = 4,
    parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
    parameter string                DEVICE     = "RTL",
    parameter string                SIMULATION = "false",
    parameter string                DEBUG      = "false"
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cke,
    input  logic [2:0]                           s_op,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]   s_a,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]   s_b,
    input  logic                                 s_clear,
    input  logic [CHANNELS-1:0]                  s_valid,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]   m_data,
    output logic [CHANNELS-1:0]                  m_valid
);

    if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("elixirchip_es1_spu_op_logic: LATENCY must be within 0..8");
    end
    if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("elixirchip_es1_spu_op_logic: CHANNELS must be within 1..16");
    end
    if (DEVICE == "") begin : g_bad_device
        $error("elixirchip_es1_spu_op_logic: DEVICE must not be empty");
    end
    if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
        $error("elixirchip_es1_spu_op_logic: SIMULATION must be \"true\" or \"false\"");
    end
    if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
        $error("elixirchip_es1_spu_op_logic: DEBUG must be \"true\" or \"false\"");
    end

    op_t                                op_s;
    logic [CHANNELS-1:0][DATA_BITS-1:0] f_s;

    assign op_s = op_t'(s_op);

    // Operation result for every lane, shared by the bypass and the pipeline
    always_comb begin
        f_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            for (int j = 0; j < DATA_BITS; j++) begin
                f_s[i][j] = op_eval_bit(op_s, s_a[i][j], s_b[i][j]);
            end
        end
    end

    if (LATENCY == 0) begin : g_bypass
        // Clock, reset, clock-enable and clear have no role without registers.
        logic unused_s;
        assign unused_s = ^{clk, reset, cke, s_clear};
        assign m_data   = f_s;
        assign m_valid  = s_valid;
    end else begin : g_pipe
        logic [CHANNELS-1:0][DATA_BITS-1:0] stg_data  [LATENCY];
        logic [CHANNELS-1:0]                stg_valid [LATENCY];
        logic [CHANNELS-1:0][DATA_BITS-1:0] data_d;
        logic [CHANNELS-1:0][DATA_BITS-1:0] data_q;
        logic [CHANNELS-1:0]                valid_d;
        logic [CHANNELS-1:0]                valid_q;

        // Compute stage: clear overrides every lane, then per-lane valid capture
        always_comb begin
            data_d  = data_q;
            valid_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s_clear) begin
                    data_d[i]  = CLEAR_DATA;
                    valid_d[i] = 1'b1;
                end else if (s_valid[i]) begin
                    data_d[i]  = f_s[i];
                    valid_d[i] = 1'b1;
                end else begin
                    data_d[i]  = data_q[i];
                    valid_d[i] = 1'b0;
                end
            end
        end

        // Compute stage registers
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= '0;
            end else if (cke) begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign stg_data[0]  = data_q;
        assign stg_valid[0] = valid_q;

        for (genvar k = 1; k < LATENCY; k++) begin : g_stage
            elixirchip_es1_spu_op_logic_stage #(
                .CHANNELS  (CHANNELS),
                .DATA_BITS (DATA_BITS)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .cke     (cke),
                .s_data  (stg_data[k-1]),
                .s_valid (stg_valid[k-1]),
                .m_data  (stg_data[k]),
                .m_valid (stg_valid[k])
            );
        end

        assign m_data  = stg_data[LATENCY-1];
        assign m_valid = stg_valid[LATENCY-1];
    end

endmodule

// File: doc/elixirchip_es1_spu_op_logic.md
# elixirchip_es1_spu_op_logic

Multi-channel, multi-function bitwise logic unit for the ES1 SPU datapath. It generalises the single-function NOT operator with three additions: a runtime-selected operation, CHANNELS parallel lanes with per-lane valid, and an explicit m_valid output. Latency is configurable, and the pipeline is gated by clock-enable. Each output lane holds its last value while no valid result arrives.

## Interface
- LATENCY, 1: pipeline depth in cycles; legal range 0..8.
- DATA_BITS, 8: bits per lane.
- CHANNELS, 4: number of parallel lanes; legal range 1..16.
- data_t, logic [DATA_BITS-1:0]: lane data type.
- CLEAR_DATA, '0: value loaded into a lane by s_clear.
- DEVICE, "RTL": target device name.
- SIMULATION, "false": simulation switch.
- DEBUG, "false": debug switch.

Ports (`[N]` below means one element per lane, i.e. CHANNELS elements):
- clk  in  1  clock; single clock domain.
- reset  in  1  reset, asynchronous, active-high.
- cke  in  1  clock enable; when 0 all state is frozen.
- s_op  in  3  operation select (op_t).
- s_a  in  data_t[CHANNELS]  operand A per lane.
- s_b  in  data_t[CHANNELS]  operand B per lane; ignored by NOT and PASS.
- s_clear  in  1  clear all lanes.
- s_valid  in  [CHANNELS]  per-lane input valid.
- m_data  out  data_t[CHANNELS]  result per lane.
- m_valid  out  [CHANNELS]  per-lane result-updated strobe.

## Operation
- op_t encoding:
  - 0 = NOT (~a), 1 = AND, 2 = OR, 3 = XOR.
  - 4 = NAND, 5 = NOR, 6 = XNOR, 7 = PASS (a).
  - All operations are bitwise; there is no carry or width growth.
- First stage, per lane i, on posedge clk with cke=1, in priority order:
  1. s_clear=1: data <= CLEAR_DATA, valid <= 1, for every lane regardless of s_valid.
  2. s_valid[i]=1: data <= f(s_op, s_a[i], s_b[i]), valid <= 1.
  3. Otherwise: data holds, valid <= 0.
- Later stages (2..LATENCY):
  - valid always shifts forward.
  - data captures only when the incoming valid=1; otherwise it holds.
- m_data and m_valid are driven by the last stage.
- m_data changes only in the cycle where m_valid=1.
- When cke=0, all data and valid registers hold, including m_valid; there is no valid loss or duplication.
- LATENCY=0 is purely combinational:
  - m_data[i] = f(s_op, s_a[i], s_b[i]).
  - m_valid = s_valid.
  - s_clear is ignored; cke and reset have no effect.
- Reset, asynchronous, takes effect immediately, including mid-pipeline:
  - every stage data <= '0 and valid <= 0.
  - m_data = '0 and m_valid = 0 while reset is high.
  - In-flight transactions are discarded.
  - The first capture occurs on the first posedge after reset deasserts.
- An illegal LATENCY or CHANNELS value is an elaboration-time error.

## Timing
- A transaction accepted at cke-qualified edge n appears on m_data and m_valid after edge n+LATENCY-1 completes. In other words, it is visible for the LATENCY-th cke-qualified cycle.
- Throughput is one transaction per lane per cke-qualified cycle, with no back-pressure.
- s_clear with s_valid in the same cycle: clear wins, and the valid lane's input is dropped.
- Lanes are independent except for the shared s_op and s_clear.

## Structure
- Package elixirchip_es1_spu_op_logic_pkg holds:
  - the op_t enum (3 bits, encodings above);
  - a function that evaluates an op_t on two operands;
  - LATENCY_MAX=8 and CHANNELS_MAX=16.
- Sub-module elixirchip_es1_spu_op_logic_stage: one lane-vector register stage with per-lane valid-gated data capture, cke, and async reset. It is instantiated LATENCY-1 times after the compute stage.
- The top level contains the compute and clear stage, a generate loop for the later stages, and the LATENCY=0 bypass.

## Test plan
- **LATENCY=2, reset check:** hold reset high → m_data=0 and m_valid=0 on all lanes. Then issue NOT, s_a[0]=8'h5A, s_valid=4'b0001 → m_data[0]=8'hA5 with m_valid[0]=1 two cycles later; lanes 1..3 unchanged.
- **Op sweep, LATENCY=1, a=8'hF0, b=8'h3C, one op per cycle:**
  - NOT→0F, AND→30, OR→FC, XOR→CC;
  - NAND→CF, NOR→03, XNOR→33, PASS→F0.
- **Clear priority:** s_clear=1 and s_valid=4'hF in the same cycle, CLEAR_DATA=8'h77 → all lanes 77 with m_valid=4'hF after LATENCY cycles.
- **cke stall, LATENCY=3:** issue one transaction, drop cke for 5 cycles mid-flight → result appears exactly once, after 3 cke-qualified cycles. m_data stays stable whenever m_valid=0.
- **Async reset mid-operation:** assert reset between clock edges while 2 transactions are in flight → outputs go to 0 immediately and no stale m_valid follows deassertion.
- **LATENCY=0, AND, a=8'hAA, b=8'h0F:** m_data=8'h0A in the same cycle; m_valid mirrors s_valid; s_clear has no effect.
